// File: rtl/crtc_timing.sv
// Character-mode CRT timing generator.
// Produces the character load strobe, display enable, raw syncs, raster
// address, video RAM address and cursor flag from the dot clock. It also
// holds a bus-writable cursor address with a blink phase.
//
// Bus strobes: W_CADDR / R_CADDR are asynchronous levels. Each one passes
// through a 2-flop shift register. An action fires once, on the cycle the
// register reads 01, which is two clocks after the rising edge. A strobe
// held high does not fire again. A write and a read that fire in the same
// cycle return the value from before the write.
module crtc_timing #(
  parameter int H_TOTAL      = 100,
  parameter int H_DISP       = 80,
  parameter int H_SYNC_START = 82,
  parameter int H_SYNC_WIDTH = 12,
  parameter int V_TOTAL      = 525,
  parameter int V_DISP       = 480,
  parameter int V_SYNC_START = 490,
  parameter int V_SYNC_WIDTH = 2,
  parameter int CHAR_H       = 16
) (
  input  logic        DOTCLOCK,
  input  logic        nRESET,
  input  logic        sec_pulse,
  input  logic        W_CADDR,
  input  logic        R_CADDR,
  input  logic [15:0] DBI,
  output logic [15:0] DBO,
  output logic        ph2,
  output logic        DE,
  output logic        HS,
  output logic        VS,
  output logic [4:0]  RA,
  output logic [13:0] MA,
  output logic        cursor
);

  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  // Timing counters: dot within character, character, scanline, raster row
  // line and the RAM address of column 0 of the current row.
  logic [2:0]    dot;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [4:0]    ra;
  logic [13:0]   row_base;

  // Cursor and bus state.
  logic [13:0] cur_addr;
  logic        cur_en;
  logic        blink;
  logic [1:0]  w_sync;
  logic [1:0]  r_sync;
  logic        w_fire;
  logic        r_fire;
  logic        dbi_unused;

  // Values one and two characters ahead of the current one.
  logic          h_last, v_last, ra_last;
  logic [HW-1:0] h_p1, h_p2;
  logic          wrap2;
  logic [VW-1:0] v_p1;
  logic [4:0]    ra_p1;
  logic [13:0]   base_p1;

  // Load target (next character): used on the edge entering dot 7.
  logic [VW-1:0] t1_v;
  logic [4:0]    t1_ra;
  logic [13:0]   t1_addr;
  logic          t1_de;

  // Character after the load target: MA for it is presented during the
  // next character window, so the RAM sees it a full window early.
  logic [13:0] t2_addr;
  logic        t2_disp;

  logic hs_next, vs_next;

  assign w_fire     = (w_sync == 2'b01);
  assign r_fire     = (r_sync == 2'b01);
  assign dbi_unused = DBI[14];

  // Lookahead arithmetic; row base advances by H_DISP instead of multiplying.
  always_comb begin
    h_last  = (h == HW'(H_TOTAL - 1));
    v_last  = (v == VW'(V_TOTAL - 1));
    ra_last = (ra == 5'(CHAR_H - 1));

    h_p1  = h_last ? '0 : h + 1'b1;
    h_p2  = (h_p1 == HW'(H_TOTAL - 1)) ? '0 : h_p1 + 1'b1;
    wrap2 = h_last || (h_p1 == HW'(H_TOTAL - 1));

    v_p1    = v_last ? '0 : v + 1'b1;
    ra_p1   = (v_last || ra_last) ? 5'd0 : ra + 5'd1;
    base_p1 = v_last ? 14'd0 : (ra_last ? row_base + 14'(H_DISP) : row_base);

    t1_v    = h_last ? v_p1 : v;
    t1_ra   = h_last ? ra_p1 : ra;
    t1_addr = (h_last ? base_p1 : row_base) + 14'(h_p1);
    t1_de   = (int'(h_p1) < H_DISP) && (int'(t1_v) < V_DISP);

    t2_addr = (wrap2 ? base_p1 : row_base) + 14'(h_p2);
    t2_disp = (int'(h_p2) < H_DISP);

    hs_next = (int'(h_p1) >= H_SYNC_START) &&
              (int'(h_p1) < H_SYNC_START + H_SYNC_WIDTH);
    vs_next = (int'(v_p1) >= V_SYNC_START) &&
              (int'(v_p1) < V_SYNC_START + V_SYNC_WIDTH);
  end

  // Dot, character, scanline, raster and row-base counters.
  always_ff @(posedge DOTCLOCK or negedge nRESET) begin
    if (!nRESET) begin
      dot      <= 3'd0;
      h        <= '0;
      v        <= '0;
      ra       <= 5'd0;
      row_base <= 14'd0;
    end else begin
      dot <= dot + 3'd1;
      if (dot == 3'd7) begin
        h <= h_p1;
        if (h_last) begin
          v        <= v_p1;
          ra       <= ra_p1;
          row_base <= base_p1;
        end
      end
    end
  end

  // Load strobe plus DE/RA/cursor for the load target, set entering dot 7.
  always_ff @(posedge DOTCLOCK or negedge nRESET) begin
    if (!nRESET) begin
      ph2    <= 1'b0;
      DE     <= 1'b0;
      RA     <= 5'd0;
      cursor <= 1'b0;
    end else begin
      ph2 <= (dot == 3'd6);
      if (dot == 3'd6) begin
        DE     <= t1_de;
        RA     <= t1_ra;
        cursor <= t1_de && cur_en && blink && (t1_addr == cur_addr);
      end
    end
  end

  // Syncs change on character boundaries; MA is updated for displayed cells only.
  always_ff @(posedge DOTCLOCK or negedge nRESET) begin
    if (!nRESET) begin
      HS <= 1'b0;
      VS <= 1'b0;
      MA <= 14'd0;
    end else if (dot == 3'd7) begin
      HS <= hs_next;
      if (h_last) VS <= vs_next;
      if (t2_disp) MA <= t2_addr;
    end
  end

  // Bus strobe detection, cursor register, readback and blink phase.
  always_ff @(posedge DOTCLOCK or negedge nRESET) begin
    if (!nRESET) begin
      w_sync   <= 2'b00;
      r_sync   <= 2'b00;
      cur_addr <= 14'd0;
      cur_en   <= 1'b1;
      blink    <= 1'b1;
      DBO      <= 16'd0;
    end else begin
      w_sync <= {w_sync[0], W_CADDR};
      r_sync <= {r_sync[0], R_CADDR};
      if (r_fire) DBO <= {cur_en, 1'b0, cur_addr};
      if (w_fire) begin
        cur_addr <= DBI[13:0];
        cur_en   <= DBI[15];
      end
      if (sec_pulse) blink <= ~blink;
    end
  end

endmodule

// File: tb/tb_crtc_timing.sv
// Testbench for crtc_timing, using a reduced raster so several frames fit
// in a short run: 20x37 characters/lines, 12x32 displayed, 8-line cells.
module tb_crtc_timing;

  localparam int HT    = 20;
  localparam int HD    = 12;
  localparam int HSS   = 14;
  localparam int HSW   = 3;
  localparam int VT    = 37;
  localparam int VD    = 32;
  localparam int VSS   = 33;
  localparam int VSW   = 2;
  localparam int CH    = 8;
  localparam int LINE  = 8 * HT;
  localparam int FRAME = LINE * VT;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sec = 1'b0;
  logic        wc = 1'b0;
  logic        rc = 1'b0;
  logic [15:0] dbi = 16'd0;
  logic [15:0] dbo;
  logic        ph2, de, hs, vs, cur;
  logic [4:0]  ra;
  logic [13:0] ma;

  always #5 clk = ~clk;

  crtc_timing #(
    .H_TOTAL(HT), .H_DISP(HD), .H_SYNC_START(HSS), .H_SYNC_WIDTH(HSW),
    .V_TOTAL(VT), .V_DISP(VD), .V_SYNC_START(VSS), .V_SYNC_WIDTH(VSW),
    .CHAR_H(CH)
  ) dut (
    .DOTCLOCK(clk), .nRESET(rst_n), .sec_pulse(sec),
    .W_CADDR(wc), .R_CADDR(rc), .DBI(dbi), .DBO(dbo),
    .ph2(ph2), .DE(de), .HS(hs), .VS(vs), .RA(ra), .MA(ma), .cursor(cur)
  );

  // ---------------- reference model ----------------
  int          t;
  logic        m_de, m_cur, m_en, m_blink;
  logic [4:0]  m_ra;
  logic [13:0] m_ma, m_caddr;
  logic [15:0] m_dbo;
  logic [1:0]  m_ws, m_rs;

  // ---------------- scoreboard ----------------
  logic [39:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int cnt_cur, cnt_de, cnt_hs, cnt_vs;
  string phase_tag = "init";

  function automatic logic [39:0] dut_vec();
    return {ph2, de, hs, vs, ra, ma, cur, dbo};
  endfunction

  function automatic logic [39:0] exp_vec();
    int h, v;
    logic p, hh, vv;
    h  = (t / 8) % HT;
    v  = (t / LINE) % VT;
    p  = (t % 8 == 7);
    hh = (h >= HSS) && (h < HSS + HSW);
    vv = (v >= VSS) && (v < VSS + VSW);
    return {p, m_de, hh, vv, m_ra, m_ma, m_cur, m_dbo};
  endfunction

  task automatic model_reset();
    t = 0;
    m_de = 1'b0; m_cur = 1'b0; m_ra = 5'd0; m_ma = 14'd0;
    m_caddr = 14'd0; m_en = 1'b1; m_blink = 1'b1;
    m_dbo = 16'd0; m_ws = 2'b00; m_rs = 2'b00;
  endtask

  // Advance the model across one rising edge, using the inputs the bench drove.
  task automatic model_edge();
    logic fw, fr;
    int g, hp, lp;
    fw = (m_ws == 2'b01);
    fr = (m_rs == 2'b01);
    m_ws = {m_ws[0], wc};
    m_rs = {m_rs[0], rc};
    t++;
    g  = t / 8 + 1;
    hp = g % HT;
    lp = (g / HT) % VT;
    if (t % 8 == 7) begin
      m_de  = (hp < HD) && (lp < VD);
      m_ra  = 5'(lp % CH);
      m_cur = m_de && m_en && m_blink && (14'((lp / CH) * HD + hp) == m_caddr);
    end
    if ((t % 8 == 0) && (hp < HD)) m_ma = 14'((lp / CH) * HD + hp);
    if (fr) m_dbo = {m_en, 1'b0, m_caddr};
    if (fw) begin
      m_caddr = dbi[13:0];
      m_en    = dbi[15];
    end
    if (sec) m_blink = ~m_blink;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    logic [39:0] e;
    @(posedge clk);
    model_edge();
    exp_q.push_back(exp_vec());
    @(negedge clk);
    e = exp_q.pop_front();
    vectors++;
    assert (dut_vec() === e) else begin
      miscompares++;
      $error("FAIL %s t=%0d observed=%h expected=%h", phase_tag, t, dut_vec(), e);
    end
    if (cur) cnt_cur++;
    if (de)  cnt_de++;
    if (hs)  cnt_hs++;
    if (vs)  cnt_vs++;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic run_to(input int target);
    while (t < target) tick();
  endtask

  task automatic clear_counts();
    cnt_cur = 0; cnt_de = 0; cnt_hs = 0; cnt_vs = 0;
  endtask

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] d);
    dbi = d; wc = 1'b1;
    run(5);
    wc = 1'b0;
    run(2);
  endtask

  task automatic bus_read(input string tag, input logic [15:0] exp);
    rc = 1'b1;
    run(4);
    rc = 1'b0;
    run(2);
    check(tag, int'(dbo), int'(exp));
  endtask

  task automatic sec_tick();
    sec = 1'b1;
    tick();
    sec = 1'b0;
  endtask

  // Count activity over one full frame period starting from the current cycle.
  task automatic frame_counts(input string tag, input int exp_cur);
    clear_counts();
    run(FRAME);
    check({tag, "_cursor_dots"}, cnt_cur, exp_cur);
    check({tag, "_de_dots"}, cnt_de, HD * 8 * VD);
    check({tag, "_hs_dots"}, cnt_hs, HSW * 8 * VT);
    check({tag, "_vs_dots"}, cnt_vs, VSW * LINE);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    model_reset();
    clear_counts();
    #1;
    phase_tag = "reset_hold";
    vectors++;
    assert (dut_vec() === 40'd0) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", phase_tag, dut_vec(), 40'd0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Free-running timing from release through frame 0.
    phase_tag = "frame0";
    run_to(33 * LINE);

    // Frame 1: default cursor at address 0 (row 0, col 0, 8 lines).
    phase_tag = "frame1";
    frame_counts("default", 64);

    // Cursor at row 2 col 5 (address 29), enable set; written in blanking.
    phase_tag = "cursor_write";
    bus_write(16'h801D);
    bus_read("readback", 16'h801D);
    phase_tag = "cursor_on";
    frame_counts("cursor_on", 64);

    phase_tag = "blink_off";
    sec_tick();
    frame_counts("blink_off", 0);

    phase_tag = "blink_on";
    sec_tick();
    frame_counts("blink_on", 64);

    // Simultaneous write and read: read returns the pre-write value.
    phase_tag = "collision";
    dbi = 16'h0003; wc = 1'b1; rc = 1'b1;
    run(4);
    wc = 1'b0; rc = 1'b0;
    run(2);
    check("collision_dbo", int'(dbo), 16'h801D);
    bus_read("post_write_dbo", 16'h0003);
    phase_tag = "cursor_disabled";
    frame_counts("disabled", 0);
    sec_tick();

    // Mid-frame asynchronous reset at scanline 20.
    phase_tag = "pre_reset";
    while (((t / LINE) % VT) != 20) tick();
    #2;
    rst_n = 1'b0;
    #1;
    phase_tag = "async_reset";
    vectors++;
    assert (dut_vec() === 40'd0) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", phase_tag, dut_vec(), 40'd0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    phase_tag = "after_reset";
    vectors++;
    assert (dut_vec() === exp_vec()) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", phase_tag, dut_vec(), exp_vec());
    end
    bus_read("reset_caddr", 16'h8000);

    // MA windows: row 2 col 5, last displayed cell, first cell of next frame.
    phase_tag = "ma_points";
    run_to(16 * LINE + 4 * 8 + 3);
    check("ma_row2_col5", int'(ma), 29);
    run_to(31 * LINE + 10 * 8 + 3);
    check("ma_last_cell", int'(ma), 47);
    run_to(36 * LINE + 19 * 8 + 3);
    check("ma_frame_wrap", int'(ma), 0);

    phase_tag = "restart_frame";
    run_to(FRAME + 33 * LINE);
    frame_counts("restart", 64);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/crtc_timing.md
Name: crtc_timing

Overview:
- Character-mode CRT timing generator; directly upstream of the video matrix stage.
- From DOTCLOCK it produces the character phase strobe (ph2), display enable (DE), raw sync (HS/VS, active-high; downstream applies polarity), scanline-in-row (RA), video RAM address (MA) and the cursor flag.
- Holds a bus-writable cursor address with sec_pulse-driven blink.
- Defaults give 640x480@60 with 8x16 cells: 80x30 characters.

Parameters:
- H_TOTAL, 100, characters per line including blanking
- H_DISP, 80, displayed characters per line
- H_SYNC_START, 82, character index where HS asserts
- H_SYNC_WIDTH, 12, HS width in characters
- V_TOTAL, 525, scanlines per frame
- V_DISP, 480, displayed scanlines; must be a multiple of CHAR_H
- V_SYNC_START, 490, scanline where VS asserts
- V_SYNC_WIDTH, 2, VS width in scanlines
- CHAR_H, 16, scanlines per character row (max 32)

Ports:
- DOTCLOCK  in  1  pixel clock; all logic on posedge
- nRESET  in  1  asynchronous active-low reset
- sec_pulse  in  1  one-DOTCLOCK pulse, once per blink half-period
- W_CADDR  in  1  cursor-address write strobe; async level, edge-detected
- R_CADDR  in  1  cursor-address read strobe; async level, edge-detected
- DBI  in  16  bus write data: [13:0] cursor address, [15] cursor enable
- DBO  out  16  bus read data
- ph2  out  1  character load strobe
- DE  out  1  display enable for the character being loaded
- HS  out  1  horizontal sync, active-high
- VS  out  1  vertical sync, active-high
- RA  out  5  scanline within character row
- MA  out  14  video RAM address of the next character
- cursor  out  1  current character is the cursor cell and blink phase is on

Behaviour:
- Reset: all counters 0.
- Reset values of outputs: ph2=0, DE=0, HS=0, VS=0, RA=0, MA=0, cursor=0, DBO=0.
- Reset values of internal state: cursor address=0, cursor enable=1, blink=1, edge detectors=00.
- Reset is asynchronous and may assert mid-frame. After release, counting restarts at dot 0, character 0, scanline 0.
- Counters:
  - dot d: 0..7.
  - character h: 0..H_TOTAL-1; increments when d=7.
  - scanline v: 0..V_TOTAL-1; increments when d=7 and h=H_TOTAL-1.
  - All counters wrap to 0.
  - Row r = v / CHAR_H. Raster address ra = v mod CHAR_H, kept as a separate counter; no divider.
- ph2: registered, high exactly one DOTCLOCK in 8, during the cycle where d=7.
- Load target: the character being loaded at a ph2 edge is the next character h' = (h+1) mod H_TOTAL, on the next line when h wraps.
- DE, RA and cursor are registered. They update on the edge entering d=7 and hold for 8 cycles, so they describe h' for the whole shift window.
  - DE = (h' < H_DISP) && (v' < V_DISP).
- HS: asserted for characters H_SYNC_START .. H_SYNC_START+H_SYNC_WIDTH-1. Changes on character boundaries (d=0), independent of DE timing.
- VS: asserted for scanlines V_SYNC_START .. V_SYNC_START+V_SYNC_WIDTH-1. Changes at d=0 of h=0.
- MA:
  - Registered at d=0 to r*H_DISP + h' for h' < H_DISP, else held.
  - Stable d=0..d=7; the video RAM has 6 cycles to return data before the ph2 edge.
  - Computed incrementally: a row base register advances by H_DISP at the start of each new row and resets to 0 at frame wrap. No multiplier.
  - 14-bit wrap is allowed.
- cursor = DE && enable && blink && (address of h' == cursor address).
  - Low on all scanlines of blanking.
  - Scanline qualification is downstream's job.
- Blink: toggles on each cycle sec_pulse=1. While enable=0, blink still toggles but cursor stays 0.
- Bus:
  - 2-flop shift detectors on W_CADDR and R_CADDR. Action fires on pattern 01, i.e. 2 cycles after the rising edge.
  - Write: cursor address <= DBI[13:0], enable <= DBI[15]. Takes effect from the next ph2.
  - Read: DBO <= {enable, 1'b0, cursor address}. DBO holds until the next read.
  - Write and read firing in the same cycle: DBO returns the pre-write value.
  - Held-high strobes fire once only.

Test Plan:
- Reset release, defaults -> ph2 period 8, first ph2 at cycle 7 after release; HS high for 96 dots starting at dot 656 of each 800-dot line; VS high on scanlines 490-491 of 525.
- DE and RA window -> DE high for exactly 640 dots/line on lines 0-479, 0 elsewhere; RA counts 0..15 and repeats 30 times; RA=0 on line 480.
- MA sequence -> at ph2 for row 2, column 5, the previous d=0..7 window holds MA=165; the last displayed cell has MA=2399; the next frame starts at MA=0.
- Cursor write then blink -> W_CADDR pulse with DBI=16'h80A5 gives cursor=1 only at the cell with MA=165 (row 2, col 5) for 16 scanlines; one sec_pulse forces cursor=0 there; a second pulse restores it.
- Readback and collision -> R_CADDR pulse gives DBO=16'h80A5. Simultaneous W_CADDR(DBI=16'h0003) and R_CADDR gives DBO=16'h80A5; a later read gives 16'h0003 and the cursor disappears because enable=0.
- Mid-frame reset -> nRESET low at scanline 300 clears all outputs immediately (asynchronously); after release, timing restarts at v=0 and the cursor address is 0.
